// File: rtl/lpddr2_frame_reader.sv
// LPDDR2 port-1 Avalon-MM read master streaming a frame into a show-ahead FIFO.
// Optional macro FRAME_READER_UNDERFLOW_CNT_EN adds a saturating underflow_count.
module lpddr2_frame_reader #(
  parameter int ADDR_W      = 27,
  parameter int FIFO_DEPTH  = 64,
  parameter int FRAME_WORDS = 2073600,
  parameter int BASE_ADDR   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              local_init_done,
  input  logic              avl_waitrequest_n,
  output logic [ADDR_W-1:0] avl_address,
  output logic              avl_read,
  output logic              avl_burstbegin,
  input  logic              avl_readdatavalid,
  input  logic [31:0]       avl_readdata,
  input  logic              pix_ready,
  output logic              pix_valid,
  output logic [23:0]       pix_data,
  output logic              pix_sof,
  output logic              frame_wrap,
`ifdef FRAME_READER_UNDERFLOW_CNT_EN
  output logic [15:0]       underflow_count,
`endif
  output logic              underflow,
  output logic              busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, STOP, FLUSH} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] idx, idx_nxt;
  logic [CW-1:0]     ocnt, fcnt;
  logic [CW:0]       credit_sum;
  logic [AW-1:0]     tag_wp, tag_rp, wp, rp;
  logic              tag_q [FIFO_DEPTH];
  logic [24:0]       mem [FIFO_DEPTH];
  logic [24:0]       head;
  logic              go, accept, launch, rdv_ok;
  logic              push, pop, starve, unused_bits;

  assign go          = enable & local_init_done;
  assign accept      = avl_read & avl_waitrequest_n;
  assign rdv_ok      = avl_readdatavalid && ocnt != '0;
  assign busy        = state != IDLE;
  assign unused_bits = ^avl_readdata[31:24];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (go) state_nxt = RUN;
      RUN:   if (!go) state_nxt = STOP;
      STOP:  if (!avl_read && ocnt == '0) state_nxt = FLUSH;
      FLUSH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // An accepted-this-cycle read already owns a FIFO slot.
  assign credit_sum = (CW+1)'(fcnt) + (CW+1)'(ocnt)
                    + (CW+1)'(accept);
  assign launch = state == RUN && go
               && (!avl_read || accept)
               && credit_sum < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    idx_nxt = idx;
    if (accept) begin
      if (idx == ADDR_W'(FRAME_WORDS - 1)) idx_nxt = '0;
      else                                 idx_nxt = idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avl_read       <= 1'b0;
      avl_burstbegin <= 1'b0;
      avl_address    <= '0;
      idx            <= '0;
      frame_wrap     <= 1'b0;
    end else begin
      avl_burstbegin <= launch;
      frame_wrap     <= accept && idx == ADDR_W'(FRAME_WORDS - 1);
      idx            <= (state == IDLE) ? '0 : idx_nxt;
      if (launch) begin
        avl_read    <= 1'b1;
        avl_address <= ADDR_W'(BASE_ADDR) + idx_nxt;
      end else if (accept) begin
        avl_read <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ocnt   <= '0;
      tag_wp <= '0;
      tag_rp <= '0;
    end else begin
      if (accept && !rdv_ok)      ocnt <= ocnt + 1'b1;
      else if (!accept && rdv_ok) ocnt <= ocnt - 1'b1;
      if (accept) tag_wp <= tag_wp + 1'b1;
      if (rdv_ok) tag_rp <= tag_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tag_q[tag_wp] <= (idx == '0);
  end

  assign push = rdv_ok;
  assign pop  = pix_valid & pix_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
    end else if (state == FLUSH) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      fcnt <= fcnt + 1'b1;
      else if (!push && pop) fcnt <= fcnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {tag_q[tag_rp], avl_readdata[23:0]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && !pop && fcnt == CW'(FIFO_DEPTH)));
    end
  end

  assign head      = mem[rp];
  assign pix_valid = fcnt != '0;
  assign pix_data  = pix_valid ? head[23:0] : '0;
  assign pix_sof   = pix_valid & head[24];

  assign starve = state == RUN && pix_ready && !pix_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) underflow <= 1'b0;
    else if (starve || (avl_readdatavalid && ocnt == '0))
      underflow <= 1'b1;
  end

`ifdef FRAME_READER_UNDERFLOW_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) underflow_count <= '0;
    else if (starve && underflow_count != 16'hFFFF)
      underflow_count <= underflow_count + 1'b1;
  end
`endif

endmodule
